mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit; MADD/MADDU enabled by MDU_MADD_EN.
// Ports: clk, rst_n, MduStart, MduOp, MduA, MduB, MduCancel -> MduBusy, Hi, Lo.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MduStart,
  input  logic [2:0]  MduOp,
  input  logic [31:0] MduA,
  input  logic [31:0] MduB,
  input  logic        MduCancel,
  output logic        MduBusy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic go;
  logic start_mul, start_div;
  logic start_mthi, start_mtlo;

  assign go = MduStart && !MduCancel;

`ifdef MDU_MADD_EN
  assign start_mul = go &&
    (MduOp[2:1] == 2'b00 || MduOp[2:1] == 2'b11);
`else
  assign start_mul = go && (MduOp[2:1] == 2'b00);
`endif
  assign start_div  = go && (MduOp[2:1] == 2'b01);
  assign start_mthi = go && (MduOp == 3'b100);
  assign start_mtlo = go && (MduOp == 3'b101);

  // op[0] selects unsigned for every arithmetic opcode.
  logic        sgn;
  logic [63:0] ea, eb, prod, acc;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs;
  logic [31:0] uq, ur, quo, rem;
  logic        is_div_q;

  assign sgn = ~op_q[0];
  assign ea  = {{32{sgn & a_q[31]}}, a_q};
  assign eb  = {{32{sgn & b_q[31]}}, b_q};
  // Low 64 bits are identical for signed and unsigned once extended.
  assign prod = ea * eb;

`ifdef MDU_MADD_EN
  assign acc = (op_q[2:1] == 2'b11) ? {hi_q, lo_q} : 64'd0;
`else
  assign acc = 64'd0;
`endif

  // Divide on magnitudes so INT_MIN / -1 wraps cleanly.
  assign neg_a = sgn & a_q[31];
  assign neg_b = sgn & b_q[31];
  assign mag_a = neg_a ? (32'd0 - a_q) : a_q;
  assign mag_b = neg_b ? (32'd0 - b_q) : b_q;
  assign dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvs;
  assign ur    = mag_a % dvs;
  assign quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem   = neg_a ? (32'd0 - ur) : ur;

  assign is_div_q = (op_q[2:1] == 2'b01);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          start_mul: begin
            state_d = RUN;
            cnt_d   = CW'(MUL_CYCLES);
            op_d    = MduOp;
            a_d     = MduA;
            b_d     = MduB;
          end
          start_div: begin
            state_d = RUN;
            cnt_d   = CW'(DIV_CYCLES);
            op_d    = MduOp;
            a_d     = MduA;
            b_d     = MduB;
          end
          start_mthi: hi_d = MduA;
          start_mtlo: lo_d = MduA;
          default: ;
        endcase
      end
      RUN: begin
        if (MduCancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (is_div_q) begin
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end else begin
              {hi_d, lo_d} = prod + acc;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign MduBusy = (state_q == RUN);
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
